// File: rtl/coef_tabl.sv
// Twiddle-factor generator: quadrant fold plus WIDTH-step CORDIC rotation.
// It produces W = cos(theta) - j*sin(theta), with theta = 2*pi*i_index/2^WIDTH.
//
// state | meaning
// IDLE  | capture i_index, load the CORDIC seed
// ITER  | one CORDIC micro-rotation per clock, WIDTH rotations in total
// FOLD  | round the result and apply the quadrant map to o_c
// DONE  | hold the result; only i_reset leaves this state
module coef_tabl #(
  parameter int WIDTH = 12
) (
  input  logic                    i_sys_clk,
  input  logic                    i_reset,
  input  logic [0:WIDTH-1]        i_index,
  output logic [0:1][0:WIDTH-1]   o_c,
  output logic                    o_done,
  output logic [0:1]              quarter,
  output logic [0:2]              state,
  output logic [0:WIDTH-1]        index_quarter
);

  // x and y carry F fractional bits. z is a 32-bit binary angle, where
  // the full circle is 2^32.
  localparam int F  = WIDTH + 4;
  localparam int XW = F + 3;
  localparam int SH = F - (WIDTH - 2);
  localparam logic [63:0] K_Q64 = ((64'd2608131497 << F) + 64'h8000_0000) >> 32;
  localparam logic signed [XW-1:0] K_Q = XW'(K_Q64);
  localparam logic signed [XW-1:0] RND = XW'(2 ** (SH - 1));
  localparam logic [4:0] LAST = 5'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ITER = 3'd1,
    FOLD = 3'd2,
    DONE = 3'd3
  } state_t;

  state_t                  st;
  logic signed [XW-1:0]    x;
  logic signed [XW-1:0]    y;
  logic signed [31:0]      z;
  logic [4:0]              cnt;
  logic signed [WIDTH-1:0] c_r;
  logic signed [WIDTH-1:0] s_r;

  function automatic logic signed [31:0] atan_rom(input logic [4:0] i);
    case (i)
      5'd0:    atan_rom = 32'h2000_0000;
      5'd1:    atan_rom = 32'h12E4_051E;
      5'd2:    atan_rom = 32'h09FB_385B;
      5'd3:    atan_rom = 32'h0511_11D4;
      5'd4:    atan_rom = 32'h028B_0D43;
      5'd5:    atan_rom = 32'h0145_D7E1;
      5'd6:    atan_rom = 32'h00A2_F61E;
      5'd7:    atan_rom = 32'h0051_7C55;
      5'd8:    atan_rom = 32'h0028_BE53;
      5'd9:    atan_rom = 32'h0014_5F2F;
      5'd10:   atan_rom = 32'h000A_2F98;
      5'd11:   atan_rom = 32'h0005_17CC;
      5'd12:   atan_rom = 32'h0002_8BE6;
      5'd13:   atan_rom = 32'h0001_45F3;
      5'd14:   atan_rom = 32'h0000_A2FA;
      5'd15:   atan_rom = 32'h0000_517D;
      5'd16:   atan_rom = 32'h0000_28BE;
      5'd17:   atan_rom = 32'h0000_145F;
      5'd18:   atan_rom = 32'h0000_0A30;
      5'd19:   atan_rom = 32'h0000_0518;
      5'd20:   atan_rom = 32'h0000_028C;
      5'd21:   atan_rom = 32'h0000_0146;
      5'd22:   atan_rom = 32'h0000_00A3;
      5'd23:   atan_rom = 32'h0000_0051;
      default: atan_rom = 32'h0000_0000;
    endcase
  endfunction

  // Round half up to WIDTH-2 fractional bits. The magnitude stays near
  // 1.0, so the truncating cast never wraps.
  assign c_r = WIDTH'((x + RND) >>> SH);
  assign s_r = WIDTH'((y + RND) >>> SH);

  assign state = st;

  always_ff @(posedge i_sys_clk) begin
    if (i_reset) begin
      st            <= IDLE;
      x             <= '0;
      y             <= '0;
      z             <= '0;
      cnt           <= '0;
      o_c           <= '0;
      o_done        <= 1'b0;
      quarter       <= '0;
      index_quarter <= '0;
    end else begin
      case (st)
        IDLE: begin
          quarter       <= i_index[0:1];
          index_quarter <= {2'b00, i_index[2:WIDTH-1]};
          x             <= K_Q;
          y             <= '0;
          z             <= {2'b00, i_index[2:WIDTH-1], {(32 - WIDTH){1'b0}}};
          cnt           <= '0;
          st            <= ITER;
        end
        ITER: begin
          if (!z[31]) begin
            x <= x - (y >>> cnt);
            y <= y + (x >>> cnt);
            z <= z - atan_rom(cnt);
          end else begin
            x <= x + (y >>> cnt);
            y <= y - (x >>> cnt);
            z <= z + atan_rom(cnt);
          end
          cnt <= cnt + 5'd1;
          if (cnt == LAST) st <= FOLD;
        end
        FOLD: begin
          // o_c[1] carries -sin.
          case (quarter)
            2'd0: begin
              o_c[0] <= c_r;
              o_c[1] <= -s_r;
            end
            2'd1: begin
              o_c[0] <= -s_r;
              o_c[1] <= -c_r;
            end
            2'd2: begin
              o_c[0] <= -c_r;
              o_c[1] <= s_r;
            end
            default: begin
              o_c[0] <= s_r;
              o_c[1] <= c_r;
            end
          endcase
          o_done <= 1'b1;
          st     <= DONE;
        end
        DONE: st <= DONE;
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_coef_tabl.sv
// Self-checking bench for coef_tabl: vector table, abort/hold sequences and a full index sweep.
module tb_coef_tabl;
  localparam int WIDTH = 12;
  localparam real PI = 3.14159265358979323846;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [0:WIDTH-1]      idx;
  logic [0:1][0:WIDTH-1] oc;
  logic                  done;
  logic [0:1]            q;
  logic [0:2]            st;
  logic [0:WIDTH-1]      iq;

  always #5 clk = ~clk;

  coef_tabl #(.WIDTH(WIDTH)) dut (
    .i_sys_clk(clk), .i_reset(rst), .i_index(idx), .o_c(oc),
    .o_done(done), .quarter(q), .state(st), .index_quarter(iq)
  );

  typedef struct {
    int index;
    int c0;
    int c1;
    int qd;
    int iqv;
  } vec_t;

  vec_t vecs[8];
  vec_t sb[$];
  int checks = 0;
  int failures = 0;

  function automatic int sx(input logic [0:WIDTH-1] v);
    logic signed [WIDTH-1:0] t;
    t = v;
    return int'(t);
  endfunction

  function automatic int rnd(input real v);
    return $rtoi($floor(v + 0.5));
  endfunction

  function automatic int exp_state(input int k);
    if (k < WIDTH) return 1;
    if (k == WIDTH) return 2;
    return 3;
  endfunction

  task automatic chk(input string name, input int act, input int expv, input int tol);
    checks++;
    if (act > expv + tol || act < expv - tol) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d tol=%0d", name, act, expv, tol);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_c0"}, sx(oc[0]), 0, 0);
    chk({tag, "_c1"}, sx(oc[1]), 0, 0);
    chk({tag, "_done"}, int'(done), 0, 0);
    chk({tag, "_quarter"}, int'(q), 0, 0);
    chk({tag, "_iq"}, int'(iq), 0, 0);
    chk({tag, "_state"}, int'(st), 0, 0);
  endtask

  // Entered at a negedge with i_reset already low; the next posedge is edge 0.
  task automatic wait_result(input bit trace);
    bit seen;
    int lat;
    vec_t e;
    seen = 0;
    lat = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (trace) chk($sformatf("state_seq_e%0d", k), int'(st), exp_state(k), 0);
      if (done) begin
        seen = 1;
        lat = k;
      end
    end
    e = sb.pop_front();
    if (!seen) begin
      chk($sformatf("done_timeout[%0d]", e.index), 0, 1, 0);
    end else begin
      if (trace) chk($sformatf("latency[%0d]", e.index), lat, WIDTH + 1, 0);
      chk($sformatf("c0[%0d]", e.index), sx(oc[0]), e.c0, 2);
      chk($sformatf("c1[%0d]", e.index), sx(oc[1]), e.c1, 2);
      chk($sformatf("quarter[%0d]", e.index), int'(q), e.qd, 0);
      chk($sformatf("iq[%0d]", e.index), int'(iq), e.iqv, 0);
    end
  endtask

  task automatic run_one(input int index, input bit trace);
    @(negedge clk);
    rst = 1'b1;
    idx = index[WIDTH-1:0];
    @(negedge clk);
    rst = 1'b0;
    wait_result(trace);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t e;
    vecs = '{
      '{0,     1024,     0, 0,   0},
      '{256,    946,  -392, 0, 256},
      '{512,    724,  -724, 0, 512},
      '{768,    392,  -946, 0, 768},
      '{1024,     0, -1024, 1,   0},
      '{2048, -1024,     0, 2,   0},
      '{3072,     0,  1024, 3,   0},
      '{3328,   392,   946, 3, 256}
    };
    rst = 1'b1;
    idx = '0;
    repeat (3) @(negedge clk);
    check_reset("por");

    foreach (vecs[i]) begin
      sb.push_back(vecs[i]);
      run_one(vecs[i].index, 1'b1);
    end

    // Reset out of DONE, then hold it: the block must stay in IDLE.
    @(negedge clk);
    rst = 1'b1;
    idx = 12'd100;
    @(negedge clk);
    check_reset("from_done");
    repeat (6) @(negedge clk);
    check_reset("hold_rst");

    // Abort during ITER, then restart with a new index.
    idx = 12'd512;
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("abort_in_iter_state", int'(st), 1, 0);
    rst = 1'b1;
    idx = 12'd768;
    @(negedge clk);
    check_reset("abort");
    rst = 1'b0;
    sb.push_back(vecs[3]);
    wait_result(1'b1);

    // Change i_index during ITER and again during DONE.
    @(negedge clk);
    rst = 1'b1;
    idx = 12'd3328;
    @(negedge clk);
    rst = 1'b0;
    sb.push_back(vecs[7]);
    repeat (3) @(negedge clk);
    idx = 12'd0;
    wait_result(1'b0);
    idx = 12'd1024;
    repeat (6) @(negedge clk);
    chk("done_hold_done", int'(done), 1, 0);
    chk("done_hold_state", int'(st), 3, 0);
    chk("done_hold_c0", sx(oc[0]), 392, 2);
    chk("done_hold_c1", sx(oc[1]), 946, 2);
    chk("done_hold_quarter", int'(q), 3, 0);

    // Full sweep against a floating-point reference.
    for (int i = 0; i < (1 << WIDTH); i++) begin
      real th;
      th = 2.0 * PI * i / real'(1 << WIDTH);
      e.index = i;
      e.c0 = rnd($cos(th) * real'(1 << (WIDTH - 2)));
      e.c1 = rnd(-$sin(th) * real'(1 << (WIDTH - 2)));
      e.qd = i >> (WIDTH - 2);
      e.iqv = i % (1 << (WIDTH - 2));
      sb.push_back(e);
      run_one(i, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
